// File: rtl/vec_mem_requester.sv
// vec_mem_requester: initiator for the banked vector/scalar data memory.
// Ports: clk, rst (async, active-high); req_* request channel (valid/ready,
//   wren, vec, addr, wdata); rsp_* load response channel (valid/ready, vec,
//   data); mem_* memory port (data, address, wren, vec_scalar, q); busy.
// One transaction in flight: IDLE -> ISSUE -> (store) IDLE
//                                          -> (load) WAIT x RD_LAT -> RESP.
module vec_mem_requester #(
   parameter int ADDR_W = 13,
   parameter int LANES  = 16,
   parameter int RD_LAT = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_wren,
   input  logic                  req_vec,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [LANES*32-1:0]   req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_vec,
   output logic [LANES*32-1:0]   rsp_data,
   output logic [LANES*32-1:0]   mem_data,
   output logic [ADDR_W-1:0]     mem_address,
   output logic                  mem_wren,
   output logic                  mem_vec_scalar,
   input  logic [LANES*32-1:0]   mem_q,
   output logic                  busy
);

   localparam int DW = LANES * 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t state;
   state_t state_nx;

   logic [ADDR_W-1:0] addr_r;
   logic              vec_r;
   logic              wren_r;
   logic [DW-1:0]     wdata_r;
   logic [DW-1:0]     rdata_r;
   logic [2:0]        lat_cnt;

   logic [DW-1:0]     wmap;
   logic [DW-1:0]     rmap;
   logic              accept;
   logic              lat_done;

   // Only the low 16 bits of each lane are meaningful on either side.
   logic unused_hi;
   assign unused_hi = ^{req_wdata, mem_q};

   assign accept   = req_valid && req_ready;
   assign lat_done = (lat_cnt == 3'(RD_LAT - 1));

   // Store data as the memory expects it. The scalar write path
   // takes lane 15, so a scalar word is mirrored into lanes 0 and 15.
   always_comb begin
      wmap = '0;
      if (req_vec) begin
         for (int i = 0; i < LANES; i++) begin
            wmap[i*32 +: 16] = req_wdata[i*32 +: 16];
         end
      end else begin
         wmap[15:0]               = req_wdata[15:0];
         wmap[(LANES-1)*32 +: 16] = req_wdata[15:0];
      end
   end

   // Load data zero-extended; scalar loads keep lane 0 only.
   always_comb begin
      rmap = '0;
      if (vec_r) begin
         for (int i = 0; i < LANES; i++) begin
            rmap[i*32 +: 16] = mem_q[i*32 +: 16];
         end
      end else begin
         rmap[15:0] = mem_q[15:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      mem_wren  = 1'b0;
      busy      = 1'b1;
      unique case (state)
         IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (accept) begin
               state_nx = ISSUE;
            end
         end
         ISSUE: begin
            mem_wren = wren_r;
            state_nx = wren_r ? IDLE : WAIT;
         end
         WAIT: begin
            if (lat_done) begin
               state_nx = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_nx = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Request registers only change on accept, so the memory port
   // holds its last address/mode while idle or waiting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_r  <= '0;
         vec_r   <= 1'b0;
         wren_r  <= 1'b0;
         wdata_r <= '0;
      end else if (accept) begin
         addr_r  <= req_addr;
         vec_r   <= req_vec;
         wren_r  <= req_wren;
         wdata_r <= wmap;
      end
   end

   // lat_cnt counts WAIT cycles; q is captured on the last one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lat_cnt <= '0;
         rdata_r <= '0;
      end else if (state == WAIT) begin
         lat_cnt <= lat_cnt + 3'd1;
         if (lat_done) begin
            rdata_r <= rmap;
         end
      end else begin
         lat_cnt <= '0;
      end
   end

   assign mem_address    = addr_r;
   assign mem_vec_scalar = vec_r;
   assign mem_data       = wdata_r;
   assign rsp_vec        = vec_r;
   assign rsp_data       = rdata_r;

endmodule
